// File: rtl/ema_feeder_if.sv
// rtl/ema_feeder_if.sv - source/filter handshake bundle for the EMA feeder
interface ema_feeder_if #(
   parameter int Win   = 16,
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic signed [Win-1:0] s_data_i;
   logic                  s_valid_i;
   logic                  s_ready_o;
   logic        [Win-2:0] alpha_cfg_i;
   logic                  clr_ovf_i;
   logic                  overflow_o;
   logic         [LW-1:0] level_o;
   logic signed [Win-1:0] x_o;
   logic        [Win-2:0] alpha_o;
   logic                  valid_o;
   logic                  busy_i;
   logic                  done_i;

   modport slave (
      input  s_data_i, s_valid_i, alpha_cfg_i, clr_ovf_i, busy_i, done_i,
      output s_ready_o, overflow_o, level_o, x_o, alpha_o, valid_o
   );

   modport master (
      output s_data_i, s_valid_i, alpha_cfg_i, clr_ovf_i, busy_i, done_i,
      input  s_ready_o, overflow_o, level_o, x_o, alpha_o, valid_o
   );
endinterface

// File: rtl/ema_feeder.sv
// rtl/ema_feeder.sv - sample FIFO that issues one sample at a time to an EMA filter
module ema_feeder #(
   parameter int Win   = 16,
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   ema_feeder_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  ovf_q, ovf_d;
   logic signed [Win-1:0] x_q, x_d;
   logic [Win-2:0]        alpha_q, alpha_d;
   logic                  valid_q, valid_d;
   logic                  full, push, drop, pop;

   logic signed [Win-1:0] fifo_mem [DEPTH];

   always_comb begin
      // Push acceptance looks only at the current level, never at a same-cycle pop.
      full = (level_q == LW'(DEPTH));
      push = bus.s_valid_i && !full;
      drop = bus.s_valid_i && full;
      pop  = (state_q == S_IDLE) && (level_q != '0) && !bus.busy_i;

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);

      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf_i) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      x_d     = pop ? fifo_mem[rd_ptr_q] : x_q;
      alpha_d = pop ? bus.alpha_cfg_i    : alpha_q;

      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pop) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (bus.done_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      valid_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         x_q      <= '0;
         alpha_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         x_q      <= x_d;
         alpha_q  <= alpha_d;
         valid_q  <= valid_d;
      end
   end

   // Storage carries no reset; pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= bus.s_data_i;
      end
   end

   assign bus.s_ready_o  = !full;
   assign bus.overflow_o = ovf_q;
   assign bus.level_o    = level_q;
   assign bus.x_o        = x_q;
   assign bus.alpha_o    = alpha_q;
   assign bus.valid_o    = valid_q;
endmodule

// File: tb/tb_ema_feeder.sv
// tb/tb_ema_feeder.sv - scoreboard bench for ema_feeder
module tb_ema_feeder;
   logic clk;
   logic rst;
   logic man_done;
   logic auto_done;
   logic auto_en;
   logic hold_chk;
   int   n_tests;
   int   n_fail;
   int   issued;

   typedef struct {
      logic [15:0] x;
      logic [14:0] a;
   } exp_t;

   exp_t exp_q[$];

   ema_feeder_if #(.Win(16), .DEPTH(8)) bus ();

   ema_feeder #(.Win(16), .DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.done_i = man_done | auto_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_issue(input logic [15:0] x, input logic [14:0] a);
      exp_t e;
      e.x = x;
      e.a = a;
      exp_q.push_back(e);
   endtask

   task automatic push_one(input logic [15:0] d);
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = d;
      @(negedge clk);
      bus.s_valid_i = 1'b0;
   endtask

   task automatic done_pulse();
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
   endtask

   // Monitor: compares every issue against the scoreboard and checks hold between issues.
   logic [15:0] last_x;
   logic [14:0] last_a;
   initial begin
      exp_t e;
      last_x = '0;
      last_a = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_x = '0;
            last_a = '0;
         end else if (bus.valid_o) begin
            issued++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_issue: got x=0x%0h expected no issue", bus.x_o);
            end else begin
               e = exp_q.pop_front();
               check("issue_x", bus.x_o, e.x);
               check("issue_alpha", 16'(bus.alpha_o), 16'(e.a));
            end
            last_x = bus.x_o;
            last_a = bus.alpha_o;
         end else if (hold_chk) begin
            check("hold_x", bus.x_o, last_x);
            check("hold_alpha", 16'(bus.alpha_o), 16'(last_a));
         end
      end
   end

   // Filter model: done_i two cycles after each observed valid_o.
   initial begin
      auto_done = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_en && bus.valid_o && !rst) begin
            @(negedge clk);
            @(negedge clk);
            auto_done = 1'b1;
            @(negedge clk);
            auto_done = 1'b0;
         end
      end
   end

   initial begin
      int issued_mark;
      int budget;
      n_tests       = 0;
      n_fail        = 0;
      issued        = 0;
      man_done      = 1'b0;
      auto_en       = 1'b0;
      hold_chk      = 1'b0;
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = '0;
      bus.alpha_cfg_i = 15'h4000;
      bus.clr_ovf_i = 1'b0;
      bus.busy_i    = 1'b0;
      rst           = 1'b1;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_level", 16'(bus.level_o), 16'd0);
      check("rst_ready", 16'(bus.s_ready_o), 16'd1);
      check("rst_ovf", 16'(bus.overflow_o), 16'd0);
      check("rst_valid", 16'(bus.valid_o), 16'd0);
      check("rst_x", bus.x_o, 16'h0000);
      check("rst_alpha", 16'(bus.alpha_o), 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      // Single sample: popped one edge after the push, valid_o the cycle after
      expect_issue(16'h1234, 15'h4000);
      push_one(16'h1234);
      check("single_level_after_push", 16'(bus.level_o), 16'd1);
      check("single_valid_before_pop", 16'(bus.valid_o), 16'd0);
      @(negedge clk);
      check("single_valid_pulse", 16'(bus.valid_o), 16'd1);
      check("single_level_after_pop", 16'(bus.level_o), 16'd0);
      @(negedge clk);
      check("single_valid_one_cycle", 16'(bus.valid_o), 16'd0);
      repeat (3) @(negedge clk);
      done_pulse();
      @(negedge clk);

      // Burst of 10 with no done: 1 issued, 8 buffered, 1 dropped
      expect_issue(16'h0100, 15'h4000);
      for (int i = 0; i < 10; i++) begin
         bus.s_valid_i = 1'b1;
         bus.s_data_i  = 16'h0100 + 16'(i);
         @(negedge clk);
      end
      bus.s_valid_i = 1'b0;
      check("burst_level", 16'(bus.level_o), 16'd8);
      check("burst_ready", 16'(bus.s_ready_o), 16'd0);
      check("burst_ovf", 16'(bus.overflow_o), 16'd1);
      bus.clr_ovf_i = 1'b1;
      @(negedge clk);
      bus.clr_ovf_i = 1'b0;
      check("burst_ovf_cleared", 16'(bus.overflow_o), 16'd0);
      check("burst_level_hold", 16'(bus.level_o), 16'd8);

      // Full FIFO with a pop in the same cycle: push still dropped
      done_pulse();
      expect_issue(16'h0101, 15'h4000);
      push_one(16'hDEAD);
      check("fullpop_level", 16'(bus.level_o), 16'd7);
      check("fullpop_ovf", 16'(bus.overflow_o), 16'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("cleanup_level", 16'(bus.level_o), 16'd0);

      // Drain four queued samples in order with done_i two cycles after each issue
      hold_chk   = 1'b1;
      bus.busy_i = 1'b1;
      expect_issue(16'h1111, 15'h4000);
      expect_issue(16'h2222, 15'h4000);
      expect_issue(16'h8001, 15'h4000);
      expect_issue(16'h7FFE, 15'h4000);
      push_one(16'h1111);
      push_one(16'h2222);
      push_one(16'h8001);
      push_one(16'h7FFE);
      check("drain_level_queued", 16'(bus.level_o), 16'd4);
      issued_mark = issued;
      auto_en     = 1'b1;
      bus.busy_i  = 1'b0;
      budget      = 0;
      while (exp_q.size() != 0 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("drain_timeout", 16'(budget < 100), 16'd1);
      check("drain_count", 16'(issued - issued_mark), 16'd4);
      repeat (5) @(negedge clk);
      auto_en = 1'b0;
      check("drain_level_empty", 16'(bus.level_o), 16'd0);

      // Alpha change during WAIT does not touch the in-flight sample
      expect_issue(16'h0ABC, 15'h4000);
      push_one(16'h0ABC);
      repeat (3) @(negedge clk);
      bus.alpha_cfg_i = 15'h7FFF;
      repeat (4) @(negedge clk);
      check("alpha_in_flight", 16'(bus.alpha_o), 16'h4000);
      expect_issue(16'h0DEF, 15'h7FFF);
      push_one(16'h0DEF);
      repeat (2) @(negedge clk);
      done_pulse();
      repeat (4) @(negedge clk);
      check("alpha_next_issue", 16'(bus.alpha_o), 16'h7FFF);
      check("alpha_next_x", bus.x_o, 16'h0DEF);
      done_pulse();
      repeat (2) @(negedge clk);

      // Reset mid-WAIT with three queued; a later done_i must not cause an issue
      bus.busy_i = 1'b1;
      expect_issue(16'h0C00, 15'h7FFF);
      for (int i = 0; i < 4; i++) push_one(16'h0C00 + 16'(i));
      bus.busy_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midwait_level", 16'(bus.level_o), 16'd3);
      #2 rst = 1'b1;
      #1;
      check("async_rst_level", 16'(bus.level_o), 16'd0);
      check("async_rst_valid", 16'(bus.valid_o), 16'd0);
      check("async_rst_x", bus.x_o, 16'h0000);
      check("async_rst_alpha", 16'(bus.alpha_o), 16'h0000);
      check("async_rst_ready", 16'(bus.s_ready_o), 16'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      issued_mark = issued;
      @(negedge clk);
      done_pulse();
      repeat (6) @(negedge clk);
      check("post_rst_no_issue", 16'(issued - issued_mark), 16'd0);
      check("post_rst_level", 16'(bus.level_o), 16'd0);
      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
